// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage with a request/ack memory port, a
// two-entry buffer (output register plus one skid register) toward the
// consumer, and redirect handling that discards an in-flight request.
// Optional feature: define FETCH_COUNT_EN to enable the consumed-instruction
// counter on fetch_cnt; otherwise fetch_cnt is tied to zero.
`timescale 1ns/1ps

module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [4:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        inst_valid,
    output logic        illegal,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] next_pc_q;
    logic [31:0] drop_addr_q;

    logic        out_valid_q;
    logic [31:0] out_inst_q;
    logic [31:0] out_pc_q;

    logic        skid_valid_q;
    logic [31:0] skid_inst_q;
    logic [31:0] skid_pc_q;

    logic        take_word;
    logic        enter_drop;
    logic        consume;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = redirect_addr & 32'hFFFF_FFFC;
    assign consume      = out_valid_q && !stall && !redirect;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (enter_drop) state_d = DROP;
            DROP:    if (imem_ack) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: memory request, its address, and the word-accept strobe.
    // In FETCH the address is next_pc directly: next_pc only moves on ack or
    // redirect, and a redirect with a pending request diverts to DROP, which
    // holds the old address in drop_addr_q, so the handshake stays stable.
    always_comb begin
        imem_req   = 1'b0;
        imem_addr  = next_pc_q;
        take_word  = 1'b0;
        enter_drop = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req   = !skid_valid_q;
                take_word  = imem_req && imem_ack && !redirect;
                enter_drop = imem_req && !imem_ack && redirect;
            end
            DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr_q;
            end
            default: ;
        endcase
    end

    // Fetch pointer: redirect target wins, otherwise advance on each accepted word
    always_ff @(posedge clk) begin
        if (rst) begin
            next_pc_q <= RESET_PC;
        end else if (redirect) begin
            next_pc_q <= redirect_tgt;
        end else if (take_word) begin
            next_pc_q <= next_pc_q + 32'd4;
        end
    end

    // Address of the request being abandoned, held while DROP waits for its ack
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_addr_q <= RESET_PC;
        end else if (enter_drop) begin
            drop_addr_q <= next_pc_q;
        end
    end

    // Output register: refilled from SKID first, then from the word acked this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
        end else if (redirect) begin
            out_valid_q <= 1'b0;
        end else if (consume) begin
            if (skid_valid_q) begin
                out_valid_q <= 1'b1;
                out_inst_q  <= skid_inst_q;
                out_pc_q    <= skid_pc_q;
            end else if (take_word) begin
                out_valid_q <= 1'b1;
                out_inst_q  <= imem_rdata;
                out_pc_q    <= next_pc_q;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (!out_valid_q && take_word) begin
            out_valid_q <= 1'b1;
            out_inst_q  <= imem_rdata;
            out_pc_q    <= next_pc_q;
        end
    end

    // Skid register: catches a word returning while OUT is held by stall
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
        end else if (redirect) begin
            skid_valid_q <= 1'b0;
        end else if (consume && skid_valid_q) begin
            skid_valid_q <= 1'b0;
        end else if (out_valid_q && !consume && take_word) begin
            skid_valid_q <= 1'b1;
            skid_inst_q  <= imem_rdata;
            skid_pc_q    <= next_pc_q;
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_cnt_q;

    // Consumed-instruction counter, wraps naturally at 32 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
        end else if (consume) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
`else
    assign fetch_cnt = '0;
`endif

    assign inst       = out_inst_q;
    assign pc         = out_pc_q;
    assign inst_valid = out_valid_q;
    assign illegal    = out_valid_q && (out_inst_q[1:0] != 2'b11);

    assign opcode = out_inst_q[6:2];
    assign func3  = out_inst_q[14:12];
    assign func7  = out_inst_q[31:25];
    assign rd     = out_inst_q[11:7];
    assign rs1    = out_inst_q[19:15];
    assign rs2    = out_inst_q[24:20];

endmodule
